// File: rtl/wasm_operand_stack_mp.sv
// Multi-port WebAssembly operand stack with tagged entries, N peek ports and a block-exit unwinder.
// Optional high-water-mark tracking is enabled by defining WASM_STACK_HWM_EN.

package wasm_stack_pkg;
   typedef enum logic [1:0] {
      TRAP_NONE            = 2'd0,
      TRAP_STACK_OVERFLOW  = 2'd1,
      TRAP_STACK_UNDERFLOW = 2'd2
   } trap_t;
endpackage

module wasm_operand_stack_mp
   import wasm_stack_pkg::*;
#(
   parameter int  DATA_W     = 64,
   parameter int  TAG_W      = 4,
   parameter int  DEPTH      = 1024,
   parameter int  PEEK_PORTS = 2,
   parameter int  MAX_KEEP   = 8,
   localparam int ENTRY_W    = TAG_W + DATA_W,
   localparam int SP_W       = $clog2(DEPTH + 1),
   localparam int KEEP_W     = $clog2(MAX_KEEP + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push_en,
   input  logic [ENTRY_W-1:0]            push_data,
   input  logic                          pop_en,
   output logic [ENTRY_W-1:0]            pop_data,
   input  logic [PEEK_PORTS*SP_W-1:0]    peek_offset,
   output logic [PEEK_PORTS*ENTRY_W-1:0] peek_data,
   input  logic                          unwind_valid,
   output logic                          unwind_ready,
   input  logic [SP_W-1:0]               unwind_height,
   input  logic [KEEP_W-1:0]             unwind_keep,
   output logic                          busy,
   output logic [SP_W-1:0]               stack_ptr,
   output logic                          empty,
   output logic                          full,
`ifdef WASM_STACK_HWM_EN
   input  logic                          hwm_clear,
   output logic [SP_W-1:0]               stack_hwm,
`endif
   output trap_t                         trap
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SUM_W  = ((SP_W > KEEP_W) ? SP_W : KEEP_W) + 1;

   typedef enum logic {ST_IDLE, ST_COPY} state_t;

   state_t              state_q, state_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic [SP_W-1:0]     src_q, src_d;
   logic [SP_W-1:0]     dst_q, dst_d;
   logic [KEEP_W-1:0]   cnt_q, cnt_d;

   logic [ENTRY_W-1:0]  mem [DEPTH];
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [ENTRY_W-1:0]  wr_data;

   logic [SP_W-1:0]     sp_m1;
   logic [SUM_W-1:0]    uw_sum;
   logic [SUM_W-1:0]    sp_ext;
   logic                uw_illegal;
   logic                uw_trivial;

   assign sp_m1        = sp_q - SP_W'(1);
   assign empty        = (sp_q == '0);
   assign full         = (sp_q == SP_W'(DEPTH));
   assign busy         = (state_q == ST_COPY);
   assign unwind_ready = !busy;
   assign stack_ptr    = sp_q;

   // Legality is judged one bit wider than the stack pointer so height+keep cannot wrap.
   assign uw_sum     = SUM_W'(unwind_height) + SUM_W'(unwind_keep);
   assign sp_ext     = SUM_W'(sp_q);
   assign uw_illegal = (uw_sum > sp_ext) || (SUM_W'(unwind_keep) > SUM_W'(MAX_KEEP));
   assign uw_trivial = (unwind_keep == '0) || (uw_sum == sp_ext);

   assign pop_data = empty ? '0 : mem[sp_m1[ADDR_W-1:0]];

   for (genvar p = 0; p < PEEK_PORTS; p++) begin : g_peek
      logic [SP_W-1:0]   off;
      logic [ADDR_W-1:0] idx;
      assign off = peek_offset[p*SP_W +: SP_W];
      assign idx = ADDR_W'(sp_q - off - SP_W'(1));
      assign peek_data[p*ENTRY_W +: ENTRY_W] = (off < sp_q) ? mem[idx] : '0;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d = state_q;
      sp_d    = sp_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      trap    = TRAP_NONE;

      case (state_q)
         ST_IDLE: begin
            if (unwind_valid) begin
               if (uw_illegal) begin
                  trap = TRAP_STACK_UNDERFLOW;
               end else if (uw_trivial) begin
                  sp_d = SP_W'(uw_sum);
               end else begin
                  src_d   = sp_q - SP_W'(unwind_keep);
                  dst_d   = unwind_height;
                  cnt_d   = unwind_keep;
                  state_d = ST_COPY;
               end
            end else if (push_en && pop_en) begin
               if (empty) begin
                  trap = TRAP_STACK_UNDERFLOW;
               end else begin
                  wr_en   = 1'b1;
                  wr_addr = sp_m1[ADDR_W-1:0];
                  wr_data = push_data;
               end
            end else if (push_en) begin
               if (full) begin
                  trap = TRAP_STACK_OVERFLOW;
               end else begin
                  wr_en   = 1'b1;
                  wr_addr = sp_q[ADDR_W-1:0];
                  wr_data = push_data;
                  sp_d    = sp_q + SP_W'(1);
               end
            end else if (pop_en) begin
               if (empty) begin
                  trap = TRAP_STACK_UNDERFLOW;
               end else begin
                  sp_d = sp_m1;
               end
            end
         end

         ST_COPY: begin
            // Ascending copy is safe because the destination always trails the source.
            wr_en   = 1'b1;
            wr_addr = dst_q[ADDR_W-1:0];
            wr_data = mem[src_q[ADDR_W-1:0]];
            src_d   = src_q + SP_W'(1);
            dst_d   = dst_q + SP_W'(1);
            cnt_d   = cnt_q - KEEP_W'(1);
            if (cnt_q == KEEP_W'(1)) begin
               sp_d    = dst_q + SP_W'(1);
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sp_q    <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the storage array has no reset; only the pointer defines which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifdef WASM_STACK_HWM_EN
   logic [SP_W-1:0] hwm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hwm_q <= '0;
      end else if (hwm_clear) begin
         hwm_q <= sp_q;
      end else if (sp_d > hwm_q) begin
         hwm_q <= sp_d;
      end
   end

   assign stack_hwm = hwm_q;
`else
   // High-water tracking is compiled out in this build.
`endif

endmodule

// File: tb/tb_wasm_operand_stack_mp.sv
// Directed self-checking bench for wasm_operand_stack_mp (DEPTH 8, two peek ports).
// High-water checks run only when WASM_STACK_HWM_EN is defined.

module tb_wasm_operand_stack_mp;
   import wasm_stack_pkg::*;

   localparam int DATA_W     = 64;
   localparam int TAG_W      = 4;
   localparam int DEPTH      = 8;
   localparam int PEEK_PORTS = 2;
   localparam int MAX_KEEP   = 8;
   localparam int ENTRY_W    = TAG_W + DATA_W;
   localparam int SP_W       = $clog2(DEPTH + 1);
   localparam int KEEP_W     = $clog2(MAX_KEEP + 1);

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          push_en;
   logic [ENTRY_W-1:0]            push_data;
   logic                          pop_en;
   logic [ENTRY_W-1:0]            pop_data;
   logic [PEEK_PORTS*SP_W-1:0]    peek_offset;
   logic [PEEK_PORTS*ENTRY_W-1:0] peek_data;
   logic                          unwind_valid;
   logic                          unwind_ready;
   logic [SP_W-1:0]               unwind_height;
   logic [KEEP_W-1:0]             unwind_keep;
   logic                          busy;
   logic [SP_W-1:0]               stack_ptr;
   logic                          empty;
   logic                          full;
   trap_t                         trap;
`ifdef WASM_STACK_HWM_EN
   logic                          hwm_clear;
   logic [SP_W-1:0]               stack_hwm;
`endif

   logic [ENTRY_W-1:0] pk0, pk1;
   assign pk0 = peek_data[0 +: ENTRY_W];
   assign pk1 = peek_data[ENTRY_W +: ENTRY_W];

   int n_checks = 0;
   int n_pass   = 0;

   wasm_operand_stack_mp #(
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W),
      .DEPTH     (DEPTH),
      .PEEK_PORTS(PEEK_PORTS),
      .MAX_KEEP  (MAX_KEEP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .push_en      (push_en),
      .push_data    (push_data),
      .pop_en       (pop_en),
      .pop_data     (pop_data),
      .peek_offset  (peek_offset),
      .peek_data    (peek_data),
      .unwind_valid (unwind_valid),
      .unwind_ready (unwind_ready),
      .unwind_height(unwind_height),
      .unwind_keep  (unwind_keep),
      .busy         (busy),
      .stack_ptr    (stack_ptr),
      .empty        (empty),
      .full         (full),
`ifdef WASM_STACK_HWM_EN
      .hwm_clear    (hwm_clear),
      .stack_hwm    (stack_hwm),
`endif
      .trap         (trap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [ENTRY_W-1:0] ent(input int tag, input longint data);
      return {TAG_W'(tag), DATA_W'(data)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      push_en      = 1'b0;
      pop_en       = 1'b0;
      push_data    = '0;
      unwind_valid = 1'b0;
      unwind_height = '0;
      unwind_keep  = '0;
`ifdef WASM_STACK_HWM_EN
      hwm_clear    = 1'b0;
`endif
   endtask

   task automatic push(input logic [ENTRY_W-1:0] e);
      push_en   = 1'b1;
      push_data = e;
      step();
      push_en   = 1'b0;
   endtask

   task automatic pop();
      pop_en = 1'b1;
      step();
      pop_en = 1'b0;
   endtask

   task automatic unwind_req(input int h, input int k);
      unwind_valid  = 1'b1;
      unwind_height = SP_W'(h);
      unwind_keep   = KEEP_W'(k);
      #1;
   endtask

   initial begin
      int nb;
      rst = 1'b1;
      peek_offset = '0;
      idle_inputs();
      #12;
      check("rst_sp", stack_ptr, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", unwind_ready, 1);
      check("rst_trap", trap, TRAP_NONE);
`ifdef WASM_STACK_HWM_EN
      check("rst_hwm", stack_hwm, 0);
`endif
      rst = 1'b0;
      step();

      // Basic push / peek / pop
      push(ent(1, 5));
      push(ent(1, 6));
      push(ent(2, 7));
      check("push3_sp", stack_ptr, 3);
      peek_offset = {SP_W'(2), SP_W'(0)};
      #1;
      check("peek_off0", pk0, ent(2, 7));
      check("peek_off2", pk1, ent(1, 5));
      peek_offset = {SP_W'(3), SP_W'(1)};
      #1;
      check("peek_off1", pk0, ent(1, 6));
      check("peek_beyond_sp", pk1, 0);
      pop_en = 1'b1;
      #1;
      check("pop_data_pre", pop_data, ent(2, 7));
      check("pop_trap", trap, TRAP_NONE);
      step();
      pop_en = 1'b0;
      check("pop_sp", stack_ptr, 2);

      // Replace top in place
      push_en = 1'b1; pop_en = 1'b1; push_data = ent(5, 'h42);
      #1;
      check("replace_trap", trap, TRAP_NONE);
      step();
      push_en = 1'b0; pop_en = 1'b0;
      check("replace_sp", stack_ptr, 2);
      check("replace_top", pop_data, ent(5, 'h42));

      // Drain, then underflow cases
      pop();
      pop();
      check("drain_empty", empty, 1);
      check("empty_pop_data", pop_data, 0);
      pop_en = 1'b1;
      #1;
      check("pop_empty_trap", trap, TRAP_STACK_UNDERFLOW);
      step();
      check("pop_empty_sp", stack_ptr, 0);
      push_en = 1'b1; push_data = ent(1, 1);
      #1;
      check("repl_empty_trap", trap, TRAP_STACK_UNDERFLOW);
      step();
      push_en = 1'b0; pop_en = 1'b0;
      check("repl_empty_sp", stack_ptr, 0);

      // Fill to DEPTH with 10..17, then overflow
      for (int i = 0; i < 8; i++) push(ent(3, 10 + i));
      check("fill_sp", stack_ptr, 8);
      check("fill_full", full, 1);
      push_en = 1'b1; push_data = ent(9, 99);
      #1;
      check("overflow_trap", trap, TRAP_STACK_OVERFLOW);
      step();
      push_en = 1'b0;
      check("overflow_sp", stack_ptr, 8);
      check("overflow_top", pop_data, ent(3, 17));

      // Unwind height 2 keep 3 with push/pop/unwind held during COPY
      unwind_req(2, 3);
      check("uw_ready", unwind_ready, 1);
      check("uw_trap", trap, TRAP_NONE);
      step();
      check("uw_busy_sp", stack_ptr, 8);
      push_en = 1'b1; pop_en = 1'b1; push_data = ent(15, 'hDEAD);
      nb = 0;
      while (busy && nb < 20) begin
         #1;
         check("busy_trap", trap, TRAP_NONE);
         check("busy_not_ready", unwind_ready, 0);
         nb++;
         step();
      end
      idle_inputs();
      check("busy_cycles", nb, 3);
      check("uw_sp", stack_ptr, 5);
      peek_offset = {SP_W'(2), SP_W'(0)};
      #1;
      check("uw_mem4", pk0, ent(3, 17));
      check("uw_mem2", pk1, ent(3, 15));
      peek_offset = {SP_W'(4), SP_W'(1)};
      #1;
      check("uw_mem3", pk0, ent(3, 16));
      check("uw_mem0", pk1, ent(3, 10));

      // Push accepted as soon as busy is low
      push(ent(4, 'h18));
      check("b2b_sp", stack_ptr, 6);
      check("b2b_top", pop_data, ent(4, 'h18));

      // Illegal unwind: 5 + 2 > 6
      unwind_req(5, 2);
      check("uw_illegal_trap", trap, TRAP_STACK_UNDERFLOW);
      step();
      idle_inputs();
      check("uw_illegal_sp", stack_ptr, 6);
      check("uw_illegal_busy", busy, 0);

      // Trivial unwinds: keep 0, and height+keep == sp
      unwind_req(3, 0);
      check("uw_k0_trap", trap, TRAP_NONE);
      step();
      idle_inputs();
      check("uw_k0_sp", stack_ptr, 3);
      check("uw_k0_busy", busy, 0);
      unwind_req(1, 2);
      step();
      idle_inputs();
      check("uw_exact_sp", stack_ptr, 3);
      check("uw_exact_busy", busy, 0);
      check("uw_exact_top", pop_data, ent(3, 15));

      // Reset during the second COPY cycle
      unwind_req(0, 2);
      step();
      idle_inputs();
      check("abort_busy1", busy, 1);
      step();
      check("abort_busy2", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_sp", stack_ptr, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", unwind_ready, 1);
      #2;
      rst = 1'b0;
      push(ent(6, 'h99));
      check("abort_push_sp", stack_ptr, 1);
      check("abort_push_idx0", pop_data, ent(6, 'h99));

`ifdef WASM_STACK_HWM_EN
      rst = 1'b1;
      #2;
      rst = 1'b0;
      check("hwm_rst", stack_hwm, 0);
      for (int i = 0; i < 5; i++) push(ent(0, i));
      check("hwm_after_push", stack_hwm, 5);
      pop(); pop(); pop();
      check("hwm_after_pop_sp", stack_ptr, 2);
      check("hwm_after_pop", stack_hwm, 5);
      hwm_clear = 1'b1;
      step();
      hwm_clear = 1'b0;
      check("hwm_clear", stack_hwm, 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
